// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Shares one bitwise logic unit (AND/OR/XOR/NOR) between two requesters.
//   Arbitration is round-robin. The result goes into a single-entry registered
//   buffer with valid/ready backpressure, which sustains one operation per cycle.
//
// Optional feature: define LOGIC_ARB_ZERO_FLAG_EN to add the res_zero output.
//   res_zero is registered with res_data and is set when the result is all zeros.
//
// Ports:
//   clk, rst                     clock; synchronous active-high reset
//   reqN_valid / reqN_ready      request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_op      operands and opcode (00 AND, 01 OR, 10 XOR, 11 NOR)
//   res_valid / res_ready        result handshake
//   res_data, res_id             buffered result and the requester that issued it
//   res_zero                     (optional) buffered result is all zeros
//   busy                         result pending or any request valid
module logic_unit_arbiter #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          PRIO_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
`ifdef LOGIC_ARB_ZERO_FLAG_EN
  output logic             res_zero,
`endif
  output logic             busy
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_id;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
  logic             r_res_zero;
`endif

  logic             w_can_accept;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_fire;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_result;

  // Shared bitwise logic unit
  function automatic logic [WIDTH-1:0] f_logic(input logic [1:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] y;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = ~(a | b);
    endcase
    return y;
  endfunction

  // Round-robin grant. A full buffer accepts a new operation only while it is
  // being drained in the same cycle.
  always_comb begin
    w_grant0     = 1'b0;
    w_grant1     = 1'b0;
    w_can_accept = (r_state == ST_EMPTY) || (r_res_valid && res_ready);
    if (!rst && w_can_accept) begin
      if (req0_valid && req1_valid) begin
        if (r_last_grant) begin
          w_grant0 = 1'b1;
        end else begin
          w_grant1 = 1'b1;
        end
      end else if (req0_valid) begin
        w_grant0 = 1'b1;
      end else if (req1_valid) begin
        w_grant1 = 1'b1;
      end
    end
  end

  // A grant is only given to a valid requester, so a grant is also a handshake.
  assign w_fire   = w_grant0 || w_grant1;
  assign w_a      = w_grant1 ? req1_a  : req0_a;
  assign w_b      = w_grant1 ? req1_b  : req0_b;
  assign w_op     = w_grant1 ? req1_op : req0_op;
  assign w_result = f_logic(w_op, w_a, w_b);

  // Buffer FSM and registered result. A new grant overwrites the buffer even
  // while it is being drained, which keeps res_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_last_grant <= ~PRIO_INIT;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_id     <= 1'b0;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
      r_res_zero   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_fire) begin
            r_state     <= ST_FULL;
            r_res_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (res_ready && !w_fire) begin
            r_state     <= ST_EMPTY;
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_res_valid <= 1'b0;
        end
      endcase
      if (w_fire) begin
        r_res_data   <= w_result;
        r_res_id     <= w_grant1;
        r_last_grant <= w_grant1;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        r_res_zero   <= (w_result == '0);
`endif
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_id     = r_res_id;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
  assign res_zero   = r_res_zero;
`endif
  assign busy       = r_res_valid || req0_valid || req1_valid;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter. Stimulus pushes the expected result
// into a scoreboard on every request handshake. A separate monitor pops and
// compares each result as the consumer takes it.
module tb_logic_unit_arbiter;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_op, req1_op;
  logic         res_valid, res_ready, res_id, busy;
  logic [W-1:0] res_data;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
  logic         res_zero;
`endif

  logic [W-1:0] exp0, exp1;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic_unit_arbiter #(.WIDTH(W), .PRIO_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id),
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    .res_zero(res_zero),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op, input logic [W-1:0] e);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op; exp0 = e;
  endtask

  task automatic drv1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op, input logic [W-1:0] e);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op; exp1 = e;
  endtask

  // Scoreboard push on request handshakes; reset discards anything pending.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (req0_valid && req0_ready) q.push_back('{1'b0, exp0});
      if (req1_valid && req1_ready) q.push_back('{1'b1, exp1});
    end
  end

  // Monitor: compare each result as the consumer takes it.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got id=%0d data=%h, expected no result", res_id, res_data);
      end else begin
        e = q.pop_front();
        chk("res_data", 32'(res_data), 32'(e.data));
        chk("res_id", 32'(res_id), 32'(e.id));
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        chk("res_zero", 32'(res_zero), 32'(e.data == '0));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g [4];
    g[0] = 1'b1; g[1] = 1'b0; g[2] = 1'b1; g[3] = 1'b0;

    // Reset held for two cycles while requester 0 is valid
    rst = 1'b1; res_ready = 1'b1;
    drv0(1'b1, 16'hF0F0, 16'h3C3C, 2'b00, 16'h3030);
    drv1(1'b0, '0, '0, 2'b00, '0);
    @(negedge clk);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    cyc();
    @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    cyc();

    // First cycle after release grants req0 (AND), then NOR back-to-back
    rst = 1'b0;
    @(negedge clk);
    chk("rel_req0_ready", 32'(req0_ready), 32'd1);
    chk("rel_req1_ready", 32'(req1_ready), 32'd0);
    cyc();
    drv0(1'b1, 16'hF0F0, 16'h3C3C, 2'b11, 16'h0303);
    @(negedge clk);
    chk("latency_res_valid", 32'(res_valid), 32'd1);
    chk("drain_grant_req0", 32'(req0_ready), 32'd1);
    cyc();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("busy_pending", 32'(busy), 32'd1);
    cyc();

    // Contention: last grant was req0, so grants alternate starting with req1
    drv0(1'b1, 16'h1234, 16'h00FF, 2'b01, 16'h12FF);
    drv1(1'b1, 16'h1234, 16'h00FF, 2'b10, 16'h12CB);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_req0_ready", 32'(req0_ready), 32'(!g[i]));
      chk("rr_req1_ready", 32'(req1_ready), 32'(g[i]));
      if (i > 0) chk("rr_no_bubble", 32'(res_valid), 32'd1);
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();

    // Backpressure: req1 XOR fills the buffer, consumer stalls three cycles
    res_ready = 1'b0;
    drv1(1'b1, 16'hAAAA, 16'h5555, 2'b10, 16'hFFFF);
    @(negedge clk);
    chk("bp_req1_ready", 32'(req1_ready), 32'd1);
    cyc();
    req1_valid = 1'b0;
    drv0(1'b1, 16'h0F0F, 16'hFFFF, 2'b00, 16'h0F0F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_req0_ready", 32'(req0_ready), 32'd0);
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_res_data", 32'(res_data), 32'h0000FFFF);
      chk("bp_res_id", 32'(res_id), 32'd1);
      cyc();
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_req0_ready", 32'(req0_ready), 32'd1);
    cyc();
    req0_valid = 1'b0;
    cyc();

    // Mid-operation reset discards the buffered result
    res_ready = 1'b0;
    drv1(1'b1, 16'hFFFF, 16'h8001, 2'b00, 16'h8001);
    @(negedge clk);
    chk("mr_req1_ready", 32'(req1_ready), 32'd1);
    cyc();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("mr_res_valid_before", 32'(res_valid), 32'd1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; res_ready = 1'b1;
    drv0(1'b1, 16'h00FF, 16'hFF00, 2'b01, 16'hFFFF);
    drv1(1'b1, 16'h00FF, 16'hFF00, 2'b00, 16'h0000);
    @(negedge clk);
    chk("mr_res_valid_after", 32'(res_valid), 32'd0);
    chk("mr_prio_req0_ready", 32'(req0_ready), 32'd1);
    chk("mr_prio_req1_ready", 32'(req1_ready), 32'd0);
    cyc();
    @(negedge clk);
    chk("mr_next_req1_ready", 32'(req1_ready), 32'd1);
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    cyc();

    @(negedge clk);
    chk("idle_res_valid", 32'(res_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
